// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB request arbiter.
package apb_arb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned TimerW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester and APB-monitor signals shared between the arbiter and its surroundings.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [APB_AW*NUM_REQ-1:0] req_addr;
    logic [APB_DW*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [APB_DW-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      transfer;
    logic [APB_AW:0]           addr_temp;
    logic [APB_DW-1:0]         data_temp;
    logic                      Psel;
    logic                      Penable;
    logic                      Pready;
    logic [APB_DW-1:0]         Prdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, Psel, Penable, Pready, Prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, addr_temp, data_temp
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, Psel, Penable, Pready, Prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, addr_temp, data_temp
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned j;
        j      = 0;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters, one transfer at a time, with a
// grant-to-completion timeout.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              Pclk,
    input logic              Presetn,
    apb_req_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               transfer_q, transfer_d;
    logic [APB_AW:0]    addr_temp_q, addr_temp_d;
    logic [APB_DW-1:0]  data_temp_q, data_temp_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    gnt_q, gnt_d;

    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;
    logic               complete;
    logic               timed_out;
    logic [NUM_REQ-1:0] gnt_onehot;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .onehot(pick_onehot),
        .idx   (pick_idx)
    );

    assign complete   = bus.Psel & bus.Penable & bus.Pready;
    assign timed_out  = (timer_q == TimerW'(TIMEOUT));
    assign gnt_onehot = NUM_REQ'(1) << gnt_q;

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_found) state_d = StIssue;
            StIssue: begin
                if (timed_out) state_d = StResp;
                else if (bus.Psel) state_d = StWait;
            end
            StWait:  if (complete || timed_out) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        transfer_d  = transfer_q;
        addr_temp_d = addr_temp_q;
        data_temp_d = data_temp_q;
        timer_d     = timer_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    req_ready_d = pick_onehot;
                    addr_temp_d = {bus.req_write[pick_idx],
                                   bus.req_addr[APB_AW*int'(pick_idx) +: APB_AW]};
                    data_temp_d = bus.req_wdata[APB_DW*int'(pick_idx) +: APB_DW];
                    transfer_d  = 1'b1;
                    ptr_d       = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    gnt_d       = pick_idx;
                    timer_d     = '0;
                end
            end
            StIssue: begin
                if (timed_out) begin
                    transfer_d  = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = gnt_onehot;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (bus.Psel) transfer_d = 1'b0;
                end
            end
            StWait: begin
                // Completion takes priority over a timeout landing on the same edge.
                if (complete) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = addr_temp_q[APB_AW] ? '0 : bus.Prdata;
                    rsp_valid_d = gnt_onehot;
                end else if (timed_out) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = gnt_onehot;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            transfer_q  <= 1'b0;
            addr_temp_q <= '0;
            data_temp_q <= '0;
            timer_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            transfer_q  <= transfer_d;
            addr_temp_q <= addr_temp_d;
            data_temp_q <= data_temp_d;
            timer_q     <= timer_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.transfer  = transfer_q;
    assign bus.addr_temp = addr_temp_q;
    assign bus.data_temp = data_temp_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small registered APB master model.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TOUT = 8;

    logic Pclk = 1'b0;
    logic Presetn = 1'b0;

    apb_req_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    apb_req_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT(TOUT)
    ) dut (
        .Pclk   (Pclk),
        .Presetn(Presetn),
        .bus    (bus)
    );

    always #5 Pclk = ~Pclk;

    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        ready_en = 1'b1;
    logic        bus_clear = 1'b0;
    logic [31:0] prdata = 32'h0;

    assign bus.Psel    = psel;
    assign bus.Penable = penable;
    assign bus.Pready  = ready_en;
    assign bus.Prdata  = prdata;

    // APB master stand-in: setup one cycle after transfer, access next, hold until Pready.
    always @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else if (bus_clear) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else if (!psel) begin
            if (bus.transfer) psel <= 1'b1;
        end else if (!penable) begin
            penable <= 1'b1;
        end else if (bus.Pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic tick;
        @(posedge Pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
        bus.req_valid[i]        = 1'b1;
        bus.req_write[i]        = wr;
        bus.req_addr[32*i +: 32]  = a;
        bus.req_wdata[32*i +: 32] = d;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.req_ready != '0) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.rsp_valid != '0) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        Presetn = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: ready=%b rsp=%b want 0000/0000",
                     bus.req_ready, bus.rsp_valid);
        end
        vectors++;
        if (bus.transfer !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status: transfer=%b err=%b rdata=%h want 0/0/0",
                     bus.transfer, bus.rsp_err, bus.rsp_rdata);
        end
        vectors++;
        if (bus.addr_temp !== 33'h0 || bus.data_temp !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_temps: addr=%h data=%h want 0/0", bus.addr_temp, bus.data_temp);
        end
        Presetn = 1'b1;
        tick();
        vectors++;
        if (bus.transfer !== 1'b0 || bus.req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: transfer=%b ready=%b want 0/0000",
                     bus.transfer, bus.req_ready);
        end
    endtask

    task automatic test_single_write;
        int c;
        set_req(0, 1'b1, 32'h10, 32'hA5A5);
        wait_grant(c);
        vectors++;
        if (c !== 1 || bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_grant: cycles=%0d ready=%b want 1/0001", c, bus.req_ready);
        end
        vectors++;
        if (bus.transfer !== 1'b1 || bus.addr_temp !== 33'h1_0000_0010 ||
            bus.data_temp !== 32'hA5A5) begin
            miscompares++;
            $display("FAIL wr_issue: transfer=%b addr=%h data=%h want 1/100000010/0000a5a5",
                     bus.transfer, bus.addr_temp, bus.data_temp);
        end
        bus.req_valid[0] = 1'b0;
        wait_rsp(c);
        vectors++;
        if (c !== 3 || bus.rsp_valid !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_rsp: cycles=%0d rsp=%b want 3/0001", c, bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_status: err=%b rdata=%h want 0/0", bus.rsp_err, bus.rsp_rdata);
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 4'b0) begin
            miscompares++;
            $display("FAIL wr_rsp_pulse: rsp=%b want 0000", bus.rsp_valid);
        end
    endtask

    task automatic test_single_read;
        int c;
        prdata = 32'hDEADBEEF;
        set_req(2, 1'b0, 32'h20, 32'h0BAD);
        wait_grant(c);
        vectors++;
        if (c !== 1 || bus.req_ready !== 4'b0100 || bus.addr_temp !== 33'h0_0000_0020) begin
            miscompares++;
            $display("FAIL rd_grant: cycles=%0d ready=%b addr=%h want 1/0100/000000020",
                     c, bus.req_ready, bus.addr_temp);
        end
        bus.req_valid[2] = 1'b0;
        wait_rsp(c);
        vectors++;
        if (c !== 3 || bus.rsp_valid !== 4'b0100) begin
            miscompares++;
            $display("FAIL rd_rsp: cycles=%0d rsp=%b want 3/0100", c, bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_data: rdata=%h err=%b want deadbeef/0", bus.rsp_rdata, bus.rsp_err);
        end
        tick();
    endtask

    task automatic test_round_robin;
        int c;
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        Presetn = 1'b0;
        tick();
        Presetn = 1'b1;
        prdata = 32'h12345678;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h100 + 32'(i), 32'h0);
        for (int n = 0; n < 5; n++) begin
            wait_grant(c);
            vectors++;
            if (c !== ((n == 0) ? 1 : 5) || bus.req_ready !== (4'b0001 << exp_idx[n])) begin
                miscompares++;
                $display("FAIL rr_grant%0d: cycles=%0d ready=%b want %0d/%b", n, c,
                         bus.req_ready, (n == 0) ? 1 : 5, 4'b0001 << exp_idx[n]);
            end
        end
        bus.req_valid = '0;
        wait_rsp(c);
        vectors++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rr_last_rsp: rsp=%b rdata=%h want 0001/12345678",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_timeout;
        int c;
        ready_en = 1'b0;
        prdata   = 32'h55AA55AA;
        set_req(1, 1'b0, 32'h30, 32'h0);
        wait_grant(c);
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_grant: ready=%b want 0010", bus.req_ready);
        end
        bus.req_valid[1] = 1'b0;
        wait_rsp(c);
        vectors++;
        if (c !== 9 || bus.rsp_valid !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_rsp: cycles=%0d rsp=%b want 9/0010", c, bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.transfer !== 1'b0) begin
            miscompares++;
            $display("FAIL to_status: err=%b rdata=%h transfer=%b want 1/0/0",
                     bus.rsp_err, bus.rsp_rdata, bus.transfer);
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_hold: rsp=%b err=%b want 0000/1", bus.rsp_valid, bus.rsp_err);
        end
        bus_clear = 1'b1;
        tick();
        bus_clear = 1'b0;
        ready_en  = 1'b1;
    endtask

    task automatic test_same_edge;
        int c;
        ready_en = 1'b0;
        prdata   = 32'hCAFEF00D;
        set_req(3, 1'b0, 32'h40, 32'h0);
        wait_grant(c);
        vectors++;
        if (bus.req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL se_grant: ready=%b want 1000", bus.req_ready);
        end
        bus.req_valid[3] = 1'b0;
        repeat (8) tick();
        vectors++;
        if (bus.rsp_valid !== 4'b0) begin
            miscompares++;
            $display("FAIL se_early: rsp=%b want 0000", bus.rsp_valid);
        end
        ready_en = 1'b1;
        tick();
        vectors++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_err !== 1'b0 ||
            bus.rsp_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL se_rsp: rsp=%b err=%b rdata=%h want 1000/0/cafef00d",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int c;
        ready_en = 1'b0;
        set_req(1, 1'b1, 32'h50, 32'h77);
        wait_grant(c);
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL rm_grant: ready=%b want 0010", bus.req_ready);
        end
        bus.req_valid[1] = 1'b0;
        tick();
        tick();
        Presetn = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.transfer !== 1'b0 ||
            bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_ctrl: ready=%b rsp=%b transfer=%b err=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.transfer, bus.rsp_err);
        end
        vectors++;
        if (bus.addr_temp !== 33'h0 || bus.data_temp !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rm_data: addr=%h data=%h rdata=%h want all 0",
                     bus.addr_temp, bus.data_temp, bus.rsp_rdata);
        end
        ready_en = 1'b1;
        tick();
        Presetn = 1'b1;
        set_req(3, 1'b0, 32'h60, 32'h0);
        set_req(1, 1'b0, 32'h64, 32'h0);
        set_req(0, 1'b0, 32'h68, 32'h0);
        wait_grant(c);
        vectors++;
        if (c !== 1 || bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rm_regrant: cycles=%0d ready=%b want 1/0001", c, bus.req_ready);
        end
        bus.req_valid = '0;
        wait_rsp(c);
        vectors++;
        if (c !== 3 || bus.rsp_valid !== 4'b0001) begin
            miscompares++;
            $display("FAIL rm_rsp: cycles=%0d rsp=%b want 3/0001", c, bus.rsp_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_same_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
